cmos_emitter: RTL and testbench

- Transmit side of the 8-bit DVP camera interface. Takes a 16-bit pixel stream with vld/sop/eop and a ready handshake, and regenerates camera-style vsync/href/8-bit data, one byte per clock.
- Two uses: a sensor emulator feeding the capture path in loopback/simulation, and a DVP-style output port for processed frames.

---
 rtl/cmos_emitter_pkg.sv | 24 ++
 rtl/dvp_timing_gen.sv | 132 +++++++++++++
 rtl/cmos_emitter.sv | 137 +++++++++++++
 tb/tb_cmos_emitter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_emitter_pkg.sv
// Shared definitions for the DVP emitter and its companion capture benches:
// FSM state encoding and the default frame geometry.
package cmos_emitter_pkg;

  localparam int unsigned COL_DEFAULT = 640;
  localparam int unsigned ROW_DEFAULT = 480;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_VSYNC = 3'd1;
  localparam logic [2:0] ST_VBP   = 3'd2;
  localparam logic [2:0] ST_LINE  = 3'd3;
  localparam logic [2:0] ST_HBLK  = 3'd4;
  localparam logic [2:0] ST_VFP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_VSYNC = ST_VSYNC,
    S_VBP   = ST_VBP,
    S_LINE  = ST_LINE,
    S_HBLK  = ST_HBLK,
    S_VFP   = ST_VFP
  } dvp_state_e;

endpackage

// File: rtl/dvp_timing_gen.sv
// Frame timing generator: walks VSYNC/VBP/LINE/HBLK/VFP and produces the
// byte phase, pixel and line counters plus registered vsync/href/busy pins.
module dvp_timing_gen
  import cmos_emitter_pkg::*;
#(
  parameter int unsigned COL  = COL_DEFAULT,
  parameter int unsigned ROW  = ROW_DEFAULT,
  parameter int unsigned VS_W = 4,
  parameter int unsigned VBP  = 8,
  parameter int unsigned HB   = 16,
  parameter int unsigned VFP  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  output dvp_state_e  state_o,
  output logic        bx_o,
  output logic [10:0] px_o,
  output logic [9:0]  ly_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic        busy_o
);

  localparam logic [10:0] PX_LAST  = 11'(COL - 1);
  localparam logic [9:0]  LY_LAST  = 10'(ROW - 1);
  localparam logic [15:0] VS_LAST  = 16'(VS_W - 1);
  localparam logic [15:0] VBP_LAST = 16'(VBP - 1);
  localparam logic [15:0] HB_LAST  = 16'(HB - 1);
  localparam logic [15:0] VFP_LAST = 16'(VFP - 1);

  dvp_state_e  state_q, state_d;
  logic        bx_q, bx_d;
  logic [10:0] px_q, px_d;
  logic [9:0]  ly_q, ly_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vsync_q, href_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bx_q    <= 1'b0;
      px_q    <= '0;
      ly_q    <= '0;
      cnt_q   <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bx_q    <= bx_d;
      px_q    <= px_d;
      ly_q    <= ly_d;
      cnt_q   <= cnt_d;
      // Pins follow the current state one clock later.
      vsync_q <= (state_q == S_VSYNC);
      href_q  <= (state_q == S_LINE);
      busy_q  <= (state_q != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = bx_q;
    px_d    = px_q;
    ly_d    = ly_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_VSYNC;
          cnt_d   = '0;
        end
      end
      S_VSYNC: begin
        if (cnt_q == VS_LAST) begin
          cnt_d   = '0;
          state_d = S_VBP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VBP: begin
        if (cnt_q == VBP_LAST) begin
          cnt_d   = '0;
          state_d = S_LINE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LINE: begin
        bx_d = ~bx_q;
        if (bx_q) begin
          if (px_q == PX_LAST) begin
            px_d    = '0;
            state_d = (ly_q < LY_LAST) ? S_HBLK : S_VFP;
          end else begin
            px_d = px_q + 11'd1;
          end
        end
      end
      S_HBLK: begin
        if (cnt_q == HB_LAST) begin
          cnt_d   = '0;
          ly_d    = ly_q + 10'd1;
          state_d = S_LINE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_VFP: begin
        if (cnt_q == VFP_LAST) begin
          cnt_d   = '0;
          ly_d    = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state_o = state_q;
  assign bx_o    = bx_q;
  assign px_o    = px_q;
  assign ly_o    = ly_q;
  assign vsync_o = vsync_q;
  assign href_o  = href_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/cmos_emitter.sv
// DVP transmit side: buffers one 16-bit pixel, serialises it high byte first
// onto dout under the generated vsync/href timing, and flags stream errors.
module cmos_emitter
  import cmos_emitter_pkg::*;
#(
  parameter int unsigned COL  = COL_DEFAULT,
  parameter int unsigned ROW  = ROW_DEFAULT,
  parameter int unsigned VS_W = 4,
  parameter int unsigned VBP  = 8,
  parameter int unsigned HB   = 16,
  parameter int unsigned VFP  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_emit,
  input  logic [15:0] din,
  input  logic        din_vld,
  input  logic        din_sop,
  input  logic        din_eop,
  output logic        din_rdy,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  dout,
  output logic        busy,
  output logic        err_underrun,
  output logic        err_frame
);

  localparam logic [10:0] PX_LAST = 11'(COL - 1);
  localparam logic [9:0]  LY_LAST = 10'(ROW - 1);

  dvp_state_e  state;
  logic        bx;
  logic [10:0] px;
  logic [9:0]  ly;

  logic [15:0] hold_q, hold_d;
  logic        hold_vld_q, hold_vld_d;
  logic        hold_sop_q, hold_sop_d;
  logic        hold_eop_q, hold_eop_d;
  logic        skip_q, skip_d;
  logic [7:0]  dout_q, dout_d;
  logic        err_underrun_q, err_underrun_d;
  logic        err_frame_q, err_frame_d;

  logic in_line, in_idle, consume, load, discard, start;
  logic first_pix, last_pix;

  dvp_timing_gen #(
    .COL (COL), .ROW (ROW), .VS_W (VS_W), .VBP (VBP), .HB (HB), .VFP (VFP)
  ) u_timing (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .state_o (state),
    .bx_o    (bx),
    .px_o    (px),
    .ly_o    (ly),
    .vsync_o (vsync),
    .href_o  (href),
    .busy_o  (busy)
  );

  // din handshake: a word transfers on any cycle with din_vld && din_rdy;
  // din_rdy depends only on the hold state and timing, never on din_vld.
  assign in_line   = (state == S_LINE);
  assign in_idle   = (state == S_IDLE);
  assign consume   = in_line && bx && hold_vld_q && !skip_q;
  assign din_rdy   = !hold_vld_q || consume;
  assign load      = din_vld && din_rdy;
  assign discard   = in_idle && hold_vld_q && !hold_sop_q;
  assign start     = in_idle && hold_vld_q && hold_sop_q && en_emit;
  assign first_pix = (px == 11'd0) && (ly == 10'd0);
  assign last_pix  = (px == PX_LAST) && (ly == LY_LAST);

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    hold_sop_d = hold_sop_q;
    hold_eop_d = hold_eop_q;
    if (load) begin
      hold_d     = din;
      hold_vld_d = 1'b1;
      hold_sop_d = din_sop;
      hold_eop_d = din_eop;
    end else if (consume || discard) begin
      hold_vld_d = 1'b0;
      hold_sop_d = 1'b0;
      hold_eop_d = 1'b0;
    end
  end

  // A pixel missing at phase 0 forfeits its whole slot, even if a word
  // lands in hold before phase 1.
  always_comb begin
    skip_d         = (in_line && !bx) ? !hold_vld_q : 1'b0;
    err_underrun_d = in_line && !bx && !hold_vld_q;
    dout_d         = 8'h00;
    if (in_line) begin
      if (!bx) begin
        dout_d = hold_vld_q ? hold_q[15:8] : 8'h00;
      end else begin
        dout_d = (hold_vld_q && !skip_q) ? hold_q[7:0] : 8'h00;
      end
    end
    err_frame_d = consume && ((hold_sop_q && !first_pix) ||
                              (hold_eop_q && !last_pix)  ||
                              (last_pix && !hold_eop_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q         <= '0;
      hold_vld_q     <= 1'b0;
      hold_sop_q     <= 1'b0;
      hold_eop_q     <= 1'b0;
      skip_q         <= 1'b0;
      dout_q         <= '0;
      err_underrun_q <= 1'b0;
      err_frame_q    <= 1'b0;
    end else begin
      hold_q         <= hold_d;
      hold_vld_q     <= hold_vld_d;
      hold_sop_q     <= hold_sop_d;
      hold_eop_q     <= hold_eop_d;
      skip_q         <= skip_d;
      dout_q         <= dout_d;
      err_underrun_q <= err_underrun_d;
      err_frame_q    <= err_frame_d;
    end
  end

  assign dout         = dout_q;
  assign err_underrun = err_underrun_q;
  assign err_frame    = err_frame_q;

endmodule

// File: tb/tb_cmos_emitter.sv
// Directed bench for cmos_emitter with a small 4x2 frame; expected bytes are
// queued by the stimulus side and a negedge monitor checks pins and widths.
module tb_cmos_emitter;

  localparam int COL  = 4;
  localparam int ROW  = 2;
  localparam int VS_W = 2;
  localparam int VBP  = 3;
  localparam int HB   = 2;
  localparam int VFP  = 2;

  logic        clk;
  logic        rst_n;
  logic        en_emit;
  logic [15:0] din;
  logic        din_vld, din_sop, din_eop;
  logic        din_rdy;
  logic        vsync, href, busy;
  logic [7:0]  dout;
  logic        err_underrun, err_frame;

  logic [7:0] exp_q[$];
  int n_vec  = 0;
  int n_fail = 0;
  bit mon_en = 1'b1;
  int uf_cnt = 0;
  int fe_cnt = 0;

  cmos_emitter #(
    .COL (COL), .ROW (ROW), .VS_W (VS_W), .VBP (VBP), .HB (HB), .VFP (VFP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_emit      (en_emit),
    .din          (din),
    .din_vld      (din_vld),
    .din_sop      (din_sop),
    .din_eop      (din_eop),
    .din_rdy      (din_rdy),
    .vsync        (vsync),
    .href         (href),
    .dout         (dout),
    .busy         (busy),
    .err_underrun (err_underrun),
    .err_frame    (err_frame)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_h, prev_v, prev_b, seen_line;
  int         hrun, vrun, low_run;
  logic [7:0] e_byte;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_h = 0; prev_v = 0; prev_b = 0; seen_line = 0;
      hrun = 0; vrun = 0; low_run = 0;
    end else begin
      if (err_underrun) uf_cnt++;
      if (err_frame) fe_cnt++;
      if (mon_en) begin
        if (href) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL dout_extra: got %0h expected no byte at %0t", dout, $time);
          end else begin
            e_byte = exp_q.pop_front();
            check("dout", dout, e_byte);
          end
          if (!prev_h) check(seen_line ? "hb_width" : "vbp_width", low_run, seen_line ? HB : VBP);
          hrun++;
          low_run = 0;
        end else if (busy) begin
          check("dout_blank", dout, 0);
        end
        if (!href && !vsync && busy) low_run++;
        if (vsync) begin
          vrun++;
          low_run = 0;
          seen_line = 0;
        end
        if (prev_v && !vsync) begin
          check("vsync_width", vrun, VS_W);
          vrun = 0;
        end
        if (prev_h && !href) begin
          check("href_width", hrun, 2 * COL);
          hrun = 0;
          seen_line = 1;
        end
        if (prev_b && !busy) begin
          check("vfp_width", low_run, VFP);
          low_run = 0;
        end
      end
      prev_h = href;
      prev_v = vsync;
      prev_b = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_pix(input logic [15:0] d, input bit s, input bit e, input int gap);
    bit acc;
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    din = d; din_sop = s; din_eop = e; din_vld = 1'b1;
    acc = 0;
    t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = din_rdy;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) check("accept_timeout", 0, 1);
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] base, input int n, input int eop_idx,
                            input int stall_idx, input int gap);
    for (int i = 0; i < n; i++)
      send_pix(base + 16'(i), i == 0, i == eop_idx, (i == stall_idx) ? gap : 0);
  endtask

  task automatic push_pix(input logic [15:0] w);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic wait_frame();
    int t;
    t = 0;
    while (!busy && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("frame_start", busy, 1);
    t = 0;
    while (busy && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("frame_end", busy, 0);
  endtask

  task automatic run_frame(input logic [15:0] base, input int n, input int eop_idx,
                           input int stall_idx, input int gap,
                           input int exp_uf, input int exp_fe);
    int u0, f0;
    u0 = uf_cnt;
    f0 = fe_cnt;
    fork
      send_frame(base, n, eop_idx, stall_idx, gap);
      wait_frame();
    join
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("exp_left", exp_q.size(), 0);
    check("underrun_pulses", uf_cnt - u0, exp_uf);
    check("frame_err_pulses", fe_cnt - f0, exp_fe);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    rst_n = 1'b0; en_emit = 1'b0;
    din = '0; din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vsync", vsync, 0);
    check("rst_href", href, 0);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_err_underrun", err_underrun, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_din_rdy", din_rdy, 1);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    en_emit = 1'b1;

    // Continuous 0x0100..0x0107.
    begin
      logic [7:0] t1 [16] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03,
                              8'h01, 8'h04, 8'h01, 8'h05, 8'h01, 8'h06, 8'h01, 8'h07};
      for (int i = 0; i < 16; i++) exp_q.push_back(t1[i]);
    end
    run_frame(16'h0100, 8, 7, -1, 0, 0, 0);

    // Pixel px=2 of line 0 missing: slot sent as 00,00, later pixels shift.
    push_pix(16'h0200); push_pix(16'h0201); push_pix(16'h0000); push_pix(16'h0202);
    push_pix(16'h0203); push_pix(16'h0204); push_pix(16'h0205); push_pix(16'h0206);
    run_frame(16'h0200, 7, 6, 2, 3, 1, 0);

    // Stray non-sop word in IDLE is dropped without starting a frame.
    send_pix(16'h1234, 1'b0, 1'b0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("stray_vsync", vsync, 0);
    check("stray_busy", busy, 0);
    check("stray_rdy", din_rdy, 1);
    for (int i = 0; i < 8; i++) push_pix(16'h0300 + 16'(i));
    run_frame(16'h0300, 8, 7, -1, 0, 0, 0);

    // eop on pixel 5: flagged there and again at the untagged last pixel.
    for (int i = 0; i < 8; i++) push_pix(16'h0400 + 16'(i));
    run_frame(16'h0400, 8, 5, -1, 0, 0, 2);

    // Reset in the middle of a line.
    mon_en = 1'b0;
    send_pix(16'h0500, 1'b1, 1'b0, 0);
    din = 16'h0501; din_vld = 1'b1;
    t = 0;
    while (!href && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("mid_href_seen", href, 1);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_vsync", vsync, 0);
    check("mid_rst_href", href, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rdy", din_rdy, 1);
    din_vld = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 8; i++) push_pix(16'h0600 + 16'(i));
    run_frame(16'h0600, 8, 7, -1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
